// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin arbiter that shares one AXI read slave between N masters,
// holding the grant from AR handshake to RLAST and answering decode errors locally with DECERR.
module axi_read_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_arvalid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
  output logic [N_MASTERS-1:0]          m_arready,
  output logic [N_MASTERS-1:0]          m_rvalid,
  input  logic [N_MASTERS-1:0]          m_rready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [1:0]                    m_rresp,
  output logic                          m_rlast,
  output logic                          s_arvalid,
  output logic [ADDR_W-1:0]             s_araddr,
  input  logic                          s_arready,
  input  logic                          s_rvalid,
  input  logic                          s_rlast,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic [1:0]                    s_rresp,
  output logic                          s_rready,
  input  logic                          decerr,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          decoder_rst
);
  localparam int IW = $clog2(N_MASTERS);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
  state_t                 r_state, w_next;
  logic [N_MASTERS-1:0]   r_grant, w_grant;
  logic [IW-1:0]          r_ptr, w_ptr, w_g, w_win, w_idx;
  logic                   w_found, w_done;
  assign grant = r_grant;
  // search starts just past the last winner so the previous winner ranks lowest
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % N_MASTERS);
      if (!w_found && m_arvalid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  always_comb begin
    w_g = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (r_grant[i]) w_g = IW'(i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= IW'(N_MASTERS - 1);
    end else begin
      r_state <= w_next;
      r_grant <= w_grant;
      r_ptr   <= w_ptr;
    end
  end
  always_comb begin
    w_next      = r_state;
    w_grant     = r_grant;
    w_ptr       = r_ptr;
    w_done      = 1'b0;
    m_arready   = '0;
    m_rvalid    = '0;
    m_rdata     = '0;
    m_rresp     = 2'b00;
    m_rlast     = 1'b0;
    s_arvalid   = 1'b0;
    s_araddr    = m_araddr[w_g*ADDR_W +: ADDR_W];
    s_rready    = 1'b0;
    decoder_rst = 1'b0;
    case (r_state)
      IDLE: if (w_found) begin
        w_grant        = '0;
        w_grant[w_win] = 1'b1;
        w_next         = ADDR;
      end
      ADDR: if (decerr) begin
        m_arready[w_g] = 1'b1;
        if (m_arvalid[w_g]) w_next = ERR;
      end else begin
        s_arvalid      = m_arvalid[w_g];
        m_arready[w_g] = s_arready;
        if (m_arvalid[w_g] && s_arready) w_next = DATA;
      end
      DATA: begin
        m_rvalid[w_g] = s_rvalid;
        m_rdata       = s_rdata;
        m_rresp       = s_rresp;
        m_rlast       = s_rlast;
        s_rready      = m_rready[w_g];
        w_done        = s_rvalid && m_rready[w_g] && s_rlast;
      end
      ERR: begin
        m_rvalid[w_g] = 1'b1;
        m_rresp       = 2'b11;
        m_rlast       = 1'b1;
        w_done        = m_rready[w_g];
      end
      default: w_next = IDLE;
    endcase
    if (w_done) begin
      w_next      = IDLE;
      w_grant     = '0;
      w_ptr       = w_g;
      decoder_rst = 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed vector table plus hand sequences for arbitration order and reset.
module tb_axi_read_arbiter;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NV = 26;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready, grant;
  logic [N*AW-1:0] m_araddr;
  logic [DW-1:0] m_rdata, s_rdata;
  logic [1:0] m_rresp, s_rresp;
  logic m_rlast, s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, decerr, decoder_rst;
  logic [AW-1:0] s_araddr;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  axi_read_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready), .s_rvalid(s_rvalid),
    .s_rlast(s_rlast), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready), .decerr(decerr),
    .grant(grant), .decoder_rst(decoder_rst));
  typedef struct {
    logic [N-1:0] av; logic sar, srv, srl; logic [DW-1:0] sd; logic [1:0] srr; logic [N-1:0] rr; logic de;
    logic [N-1:0] eg, ear; logic esav; logic [N-1:0] erv; logic esrr; logic [DW-1:0] ed;
    logic [1:0] eresp; logic erl, edr;
  } vec_t;
  vec_t vecs [NV];
  function automatic vec_t mk(
    input logic [N-1:0] av, input logic sar, srv, srl, input logic [DW-1:0] sd, input logic [1:0] srr,
    input logic [N-1:0] rr, input logic de, input logic [N-1:0] eg, ear, input logic esav,
    input logic [N-1:0] erv, input logic esrr, input logic [DW-1:0] ed, input logic [1:0] eresp,
    input logic erl, edr);
    vec_t v;
    v.av = av; v.sar = sar; v.srv = srv; v.srl = srl; v.sd = sd; v.srr = srr; v.rr = rr; v.de = de;
    v.eg = eg; v.ear = ear; v.esav = esav; v.erv = erv; v.esrr = esrr; v.ed = ed; v.eresp = eresp;
    v.erl = erl; v.edr = edr;
    return v;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_grant"}, 0, 64'(grant), 0);
    chk({nm, "_arready"}, 0, 64'(m_arready), 0);
    chk({nm, "_rvalid"}, 0, 64'(m_rvalid), 0);
    chk({nm, "_s_arvalid"}, 0, 64'(s_arvalid), 0);
    chk({nm, "_s_rready"}, 0, 64'(s_rready), 0);
    chk({nm, "_rdata"}, 0, 64'(m_rdata), 0);
    chk({nm, "_rresp"}, 0, 64'(m_rresp), 0);
    chk({nm, "_rlast"}, 0, 64'(m_rlast), 0);
    chk({nm, "_decoder_rst"}, 0, 64'(decoder_rst), 0);
  endtask
  task automatic wait_g(input bit want_zero, input string nm);
    int c;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((grant == '0) == want_zero) break;
    end
    if (c == 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout %s: grant stuck at %0h", nm, grant);
    end
  endtask
  initial begin
    int k, zeros;
    logic [N-1:0] prev;
    m_arvalid = '0; m_rready = '0; s_arready = 0; s_rvalid = 0; s_rlast = 0;
    s_rdata = '0; s_rresp = '0; decerr = 0;
    m_araddr = {32'h0000_3010, 32'h0000_2010, 32'h0000_0100, 32'h0000_0010};
    vecs[0]  = mk(4'b0010,0,0,0,0,0,4'b0000,0, 4'b0000,4'b0000,0,4'b0000,0,0,0,0,0);
    vecs[1]  = mk(4'b0010,1,0,0,0,0,4'b0000,0, 4'b0010,4'b0010,1,4'b0000,0,0,0,0,0);
    vecs[2]  = mk(4'b0000,0,1,0,32'hA000_0001,0,4'b0010,0, 4'b0010,4'b0000,0,4'b0010,1,32'hA000_0001,0,0,0);
    vecs[3]  = mk(4'b0000,0,1,0,32'hA000_0002,0,4'b0010,0, 4'b0010,4'b0000,0,4'b0010,1,32'hA000_0002,0,0,0);
    vecs[4]  = mk(4'b0000,0,1,0,32'hA000_0003,2,4'b0010,0, 4'b0010,4'b0000,0,4'b0010,1,32'hA000_0003,2,0,0);
    vecs[5]  = mk(4'b0000,0,1,1,32'hA000_0004,0,4'b0010,0, 4'b0010,4'b0000,0,4'b0010,1,32'hA000_0004,0,1,1);
    vecs[6]  = mk(4'b0000,0,0,0,0,0,4'b0000,0, 4'b0000,4'b0000,0,4'b0000,0,0,0,0,0);
    vecs[7]  = mk(4'b0001,0,0,0,0,0,4'b0000,0, 4'b0000,4'b0000,0,4'b0000,0,0,0,0,0);
    vecs[8]  = mk(4'b0001,0,0,0,0,0,4'b0000,0, 4'b0001,4'b0000,1,4'b0000,0,0,0,0,0);
    vecs[9]  = mk(4'b0001,1,0,0,0,0,4'b0000,0, 4'b0001,4'b0001,1,4'b0000,0,0,0,0,0);
    vecs[10] = mk(4'b0000,0,1,0,32'hB000_0001,0,4'b0001,0, 4'b0001,4'b0000,0,4'b0001,1,32'hB000_0001,0,0,0);
    for (int i = 11; i < 16; i++)
      vecs[i] = mk(4'b0000,0,1,0,32'hB000_0002,0,4'b0000,0, 4'b0001,4'b0000,0,4'b0001,0,32'hB000_0002,0,0,0);
    vecs[16] = mk(4'b0000,0,1,0,32'hB000_0002,0,4'b0001,0, 4'b0001,4'b0000,0,4'b0001,1,32'hB000_0002,0,0,0);
    vecs[17] = mk(4'b0000,0,1,1,32'hB000_0003,0,4'b0001,0, 4'b0001,4'b0000,0,4'b0001,1,32'hB000_0003,0,1,1);
    vecs[18] = mk(4'b0000,0,0,0,0,0,4'b0000,0, 4'b0000,4'b0000,0,4'b0000,0,0,0,0,0);
    vecs[19] = mk(4'b0100,0,0,0,0,0,4'b0000,0, 4'b0000,4'b0000,0,4'b0000,0,0,0,0,0);
    vecs[20] = mk(4'b0100,0,0,0,0,0,4'b0000,1, 4'b0100,4'b0100,0,4'b0000,0,0,0,0,0);
    for (int i = 21; i < 24; i++)
      vecs[i] = mk(4'b0000,0,1,0,32'hDEAD_BEEF,0,4'b0000,0, 4'b0100,4'b0000,0,4'b0100,0,0,3,1,0);
    vecs[24] = mk(4'b0000,0,1,0,32'hDEAD_BEEF,0,4'b0100,0, 4'b0100,4'b0000,0,4'b0100,0,0,3,1,1);
    vecs[25] = mk(4'b0000,0,0,0,0,0,4'b0000,0, 4'b0000,4'b0000,0,4'b0000,0,0,0,0,0);
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      m_arvalid = vecs[i].av; s_arready = vecs[i].sar; s_rvalid = vecs[i].srv; s_rlast = vecs[i].srl;
      s_rdata = vecs[i].sd; s_rresp = vecs[i].srr; m_rready = vecs[i].rr; decerr = vecs[i].de;
      @(negedge clk);
      chk("grant", i, 64'(grant), 64'(vecs[i].eg));
      chk("m_arready", i, 64'(m_arready), 64'(vecs[i].ear));
      chk("s_arvalid", i, 64'(s_arvalid), 64'(vecs[i].esav));
      chk("m_rvalid", i, 64'(m_rvalid), 64'(vecs[i].erv));
      chk("s_rready", i, 64'(s_rready), 64'(vecs[i].esrr));
      chk("m_rdata", i, 64'(m_rdata), 64'(vecs[i].ed));
      chk("m_rresp", i, 64'(m_rresp), 64'(vecs[i].eresp));
      chk("m_rlast", i, 64'(m_rlast), 64'(vecs[i].erl));
      chk("decoder_rst", i, 64'(decoder_rst), 64'(vecs[i].edr));
    end
    @(negedge clk);
    rst = 1;
    m_arvalid = 4'b1111; s_arready = 1; s_rvalid = 1; s_rlast = 1; m_rready = 4'b1111;
    s_rdata = 32'h5555_0000; decerr = 0;
    #2 rst = 0;
    k = 0; zeros = 0; prev = '0;
    for (int c = 0; c < 80 && k < 6; c++) begin
      @(negedge clk);
      if (grant == '0) zeros++;
      else if (prev == '0) begin
        chk("rr_grant", k, 64'(grant), 64'(1) << (k % 4));
        if (k > 0) chk("rr_idle_gap", k, 64'(zeros >= 1), 1);
        zeros = 0;
        k++;
      end
      prev = grant;
    end
    if (k < 6) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout rr_order: only %0d grants seen", k);
    end
    wait_g(1, "rr_drain");
    m_arvalid = 4'b1000;
    wait_g(0, "lone3_a");
    chk("lone3_first", 0, 64'(grant), 64'(4'b1000));
    wait_g(1, "lone3_b");
    wait_g(0, "lone3_c");
    chk("lone3_again", 0, 64'(grant), 64'(4'b1000));
    wait_g(1, "lone3_d");
    m_arvalid = 4'b0010; s_rvalid = 0; s_rlast = 0; m_rready = '0;
    wait_g(0, "rst_addr");
    chk("rst_s_arvalid", 0, 64'(s_arvalid), 1);
    chk("rst_s_araddr", 0, 64'(s_araddr), 64'h100);
    @(negedge clk);
    m_arvalid = '0; s_rvalid = 1; s_rdata = 32'hC000_0001; m_rready = 4'b0010;
    #1 chk("rst_beat1", 0, 64'({m_rvalid, m_rdata}), 64'({4'b0010, 32'hC000_0001}));
    @(negedge clk);
    s_rdata = 32'hC000_0002;
    #1 chk("rst_beat2", 0, 64'({m_rvalid, m_rdata}), 64'({4'b0010, 32'hC000_0002}));
    #1 rst = 1;
    #1 chk_reset_vals("midrst");
    m_arvalid = 4'b1111; s_rvalid = 0; m_rready = '0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_grant", 0, 64'(grant), 64'(4'b0001));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Round-robin arbiter that shares one AXI read slave port between N_MASTERS read masters in the interconnect. It grants one master at a time and holds the grant from the AR handshake until the final R beat (RLAST). It steers AR and R signals between the granted master and the slave port. On an address decode error it answers the master itself with a single DECERR beat and pulses a reset to the address decoder when each transaction ends.

## Interface
- N_MASTERS, 4, number of requesting masters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- m_arvalid  in  N_MASTERS  per-master AR valid
- m_araddr  in  N_MASTERS*ADDR_W  per-master address, master i at bits [i*ADDR_W +: ADDR_W]
- m_arready  out  N_MASTERS  per-master AR ready
- m_rvalid  out  N_MASTERS  per-master R valid
- m_rready  in  N_MASTERS  per-master R ready
- m_rdata  out  DATA_W  shared R data; qualified by m_rvalid[i]
- m_rresp  out  2  shared R response
- m_rlast  out  1  shared R last
- s_arvalid  out  1  slave AR valid
- s_araddr  out  ADDR_W  slave AR address
- s_arready  in  1  slave AR ready
- s_rvalid, s_rlast  in  1 each  slave R valid / last
- s_rdata  in  DATA_W; s_rresp  in  2
- s_rready  out  1  slave R ready
- decerr  in  1  combinational decode error for the current s_araddr
- grant  out  N_MASTERS  one-hot current grant (0 when idle)
- decoder_rst  out  1  one-cycle pulse at transaction end

## Operation
- States: IDLE, ADDR, DATA, ERR. Registers: state, grant, last-winner pointer ptr.
- IDLE:
  - If any m_arvalid is set, register as grant the first requester searching from ptr+1 upward, with modulo N_MASTERS wrap.
  - Go to ADDR.
  - If nothing is requesting, stay in IDLE.
- ADDR (g = granted index):
  - s_araddr = m_araddr[g].
  - If decerr=1: s_arvalid=0, m_arready[g]=1. When m_arvalid[g]=1, go to ERR.
  - Otherwise: s_arvalid = m_arvalid[g], m_arready[g] = s_arready. On s_arvalid && s_arready, go to DATA.
- DATA:
  - m_rvalid[g] = s_rvalid; m_rdata/m_rresp/m_rlast = s_rdata/s_rresp/s_rlast.
  - s_rready = m_rready[g].
  - On s_rvalid && s_rready && s_rlast: go to IDLE, set ptr=g, clear grant, decoder_rst=1 for that cycle.
- ERR:
  - m_rvalid[g]=1, m_rresp=2'b11, m_rlast=1, m_rdata=0. The slave is not touched.
  - On m_rready[g]: go to IDLE, set ptr=g, clear grant, decoder_rst=1.
- All non-granted m_arready and m_rvalid bits are 0 in every state. s_rready=0 outside DATA. s_arvalid=0 outside ADDR.
- Fairness: a master that has just been served has the lowest priority next round. Any requester is served within N_MASTERS transactions.
- Master deasserting m_arvalid in ADDR before the handshake (protocol violation): the arbiter stays in ADDR. No timeout.
- Simultaneous requests in IDLE: only one grant; the others remain pending.

## Timing
- Reset values: state=IDLE, grant=0, ptr=N_MASTERS-1 (master 0 wins first), decoder_rst=0. All valid/ready outputs are 0; m_rresp=0, m_rlast=0, m_rdata=0.
- rst asserted mid-transaction: return to IDLE immediately and asynchronously; the in-flight transaction is abandoned.
- Arbitration latency: request seen in IDLE at cycle T, grant visible at T+1. The earliest AR handshake is T+1.
- AR and R paths are combinational pass-through while granted (zero added latency per beat).
- Minimum turnaround: after the last-beat cycle, IDLE holds one cycle before the next grant. Back-to-back transactions are therefore spaced by at least 1 idle cycle.
- ERR response appears the cycle after the AR accept and holds until m_rready.
- decoder_rst asserts combinationally in the completing cycle only.

## Test plan
- Single master 1, addr 0x100, slave returns 4 beats:
  - grant=0010 one cycle after m_arvalid.
  - All 4 beats reach master 1 only; m_rlast on beat 4.
  - decoder_rst pulses once; grant=0 next cycle.
- Masters 0,1,2,3 requesting continuously, single-beat reads:
  - Grant order 0,1,2,3,0,1.
  - Each grant is separated by at least 1 IDLE cycle.
- decerr=1 for master 2's address:
  - m_arready[2]=1; s_arvalid stays 0.
  - Next cycle m_rvalid[2]=1, m_rresp=3, m_rlast=1. Hold with m_rready[2]=0 for 3 cycles; the beat stays asserted until m_rready rises.
  - IDLE follows; decoder_rst pulses.
- Backpressure: m_rready[0] low for 5 cycles mid-burst. s_rready mirrors it; no beat is lost or duplicated.
- Assert rst during DATA at beat 2:
  - All outputs go to reset values immediately.
  - After release, master 0 wins first.
- Master 3 requests alone after master 3 was just served:
  - It is granted again; the pointer does not starve a lone requester.
